// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order instruction-memory requests,
// buffers responses in a small fetch FIFO and drives the IF/ID register.
// Redirects restart fetch at the EX target and squash stale responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_pc,
  input  logic        stall_ifid,
  input  logic        flush_ifid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus_4,
  output logic [31:0] ifid_instr
);

  // Counter width leaves headroom so live+drop and live+fifo sums never wrap.
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CW-1:0] FIFO_DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C    = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]   NOP_INSTR    = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [CW-1:0] live_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;

  // Request-PC queue holds only live (unsquashed) requests; its occupancy is live_cnt.
  logic [31:0]   rq_pc [MAX_OUTSTANDING];
  logic [QW-1:0] rq_rd_ptr;
  logic [QW-1:0] rq_wr_ptr;

  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [FW-1:0] fifo_rd_ptr;
  logic [FW-1:0] fifo_wr_ptr;

  logic        accept;
  logic        rsp_drop;
  logic        rsp_live;
  logic        rsp_keep;
  logic        ifid_load;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        fifo_push;
  logic        bypass;
  logic [31:0] rsp_pc;

  function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  function automatic logic [QW-1:0] rq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  // Request credit check, response classification and IF/ID source selection.
  always_comb begin
    imem_req_valid = rst_n && !redirect_valid && !stall_pc &&
                     ((live_cnt + drop_cnt) < MAX_OUT_C) &&
                     ((live_cnt + fifo_count) < FIFO_DEPTH_C);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_live       = imem_rsp_valid && (drop_cnt == '0);
    // A live response landing in a redirect cycle is wrong-path and discarded.
    rsp_keep       = rsp_live && !redirect_valid;
    ifid_load      = !flush_ifid && !stall_ifid;
    fifo_empty     = (fifo_count == '0);
    // The FIFO is being cleared on redirect, so its head is never consumed then.
    fifo_pop       = ifid_load && !fifo_empty && !redirect_valid;
    bypass         = rsp_keep && fifo_empty && ifid_load;
    fifo_push      = rsp_keep && !bypass;
    rsp_pc         = rq_pc[rq_rd_ptr];
  end

  // PC: redirect wins, otherwise advance by one word per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (accept) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Outstanding-request bookkeeping: live requests become drops on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_cnt  <= '0;
      drop_cnt  <= '0;
      rq_rd_ptr <= '0;
      rq_wr_ptr <= '0;
    end else if (redirect_valid) begin
      drop_cnt  <= drop_cnt + live_cnt - CW'(imem_rsp_valid);
      live_cnt  <= '0;
      rq_rd_ptr <= rq_wr_ptr;
    end else begin
      live_cnt <= live_cnt + CW'(accept) - CW'(rsp_live);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
      if (accept) begin
        rq_wr_ptr <= rq_inc(rq_wr_ptr);
      end
      if (rsp_live) begin
        rq_rd_ptr <= rq_inc(rq_rd_ptr);
      end
    end
  end

  // Request-PC storage: record the address of every accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      rq_pc[rq_wr_ptr] <= pc_q;
    end
  end

  // Fetch FIFO pointers and occupancy; emptied on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_ptr <= '0;
      fifo_wr_ptr <= '0;
      fifo_count  <= '0;
    end else if (redirect_valid) begin
      fifo_rd_ptr <= '0;
      fifo_wr_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
      if (fifo_push) begin
        fifo_wr_ptr <= fifo_inc(fifo_wr_ptr);
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= fifo_inc(fifo_rd_ptr);
      end
    end
  end

  // Fetch FIFO storage: {pc, instr} pairs of live responses not bypassed.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc[fifo_wr_ptr]    <= rsp_pc;
      fifo_instr[fifo_wr_ptr] <= imem_rsp_data;
    end
  end

  // IF/ID register: flush, then stall, then FIFO head, then bypass, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid     <= 1'b0;
      ifid_pc        <= 32'd0;
      ifid_pc_plus_4 <= 32'd4;
      ifid_instr     <= NOP_INSTR;
    end else if (flush_ifid) begin
      ifid_valid <= 1'b0;
    end else if (!stall_ifid) begin
      if (fifo_pop) begin
        ifid_valid     <= 1'b1;
        ifid_pc        <= fifo_pc[fifo_rd_ptr];
        ifid_pc_plus_4 <= fifo_pc[fifo_rd_ptr] + 32'd4;
        ifid_instr     <= fifo_instr[fifo_rd_ptr];
      end else if (bypass) begin
        ifid_valid     <= 1'b1;
        ifid_pc        <= rsp_pc;
        ifid_pc_plus_4 <= rsp_pc + 32'd4;
        ifid_instr     <= imem_rsp_data;
      end else begin
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_pc;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus_4;
  logic [31:0] ifid_instr;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] acc_log   [$];

  fetch_stage #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_pc       (stall_pc),
    .stall_ifid     (stall_ifid),
    .flush_ifid     (flush_ifid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus_4 (ifid_pc_plus_4),
    .ifid_instr     (ifid_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // In-order imem: response appears exactly lat cycles after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'd0;
      cyc            <= 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        acc_log.push_back(imem_req_addr);
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= instr_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
    chk({tag, "_pc"}, ifid_pc, pc);
    chk({tag, "_pc4"}, ifid_pc_plus_4, pc + 32'd4);
    chk({tag, "_instr"}, ifid_instr, instr_of(pc));
  endtask

  // Assert reset for two cycles and release it on a falling edge (cycle 0).
  task automatic do_reset(input int latency);
    rst_n          = 1'b0;
    stall_pc       = 1'b0;
    stall_ifid     = 1'b0;
    flush_ifid     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_req_ready = 1'b1;
    lat            = latency;
    acc_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]  pat;
  logic [31:0] exp_addr;

  initial begin
    rst_n = 1'b0; stall_pc = 1'b0; stall_ifid = 1'b0; flush_ifid = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; imem_req_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_pc4", ifid_pc_plus_4, 32'd4);
    chk("rst_ifid_instr", ifid_instr, 32'h0000_0013);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Streaming with 1-cycle imem: one instruction per cycle from cycle 2.
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("t1_c%0d_req_valid", k), {31'd0, imem_req_valid}, 32'd1);
      chk($sformatf("t1_c%0d_req_addr", k), imem_req_addr, 32'(4 * k));
      if (k >= 2) check_ifid($sformatf("t1_c%0d", k), 32'(4 * (k - 2)));
      else chk($sformatf("t1_c%0d_ifid_valid", k), {31'd0, ifid_valid}, 32'd0);
    end

    // Load-use stall at ifid_pc=8, then IF/ID-only stall filling the FIFO.
    do_reset(1);
    repeat (4) @(negedge clk);
    stall_pc = 1'b1; stall_ifid = 1'b1; #1;
    check_ifid("t2_c4", 32'h8);
    chk("t2_c4_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk); #1;
    check_ifid("t2_c5", 32'h8);
    chk("t2_c5_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk); stall_pc = 1'b0; stall_ifid = 1'b0; #1;
    check_ifid("t2_c6", 32'h8);
    chk("t2_c6_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_c6_req_addr", imem_req_addr, 32'h10);
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk); #1;
      check_ifid($sformatf("t2_c%0d", k), 32'(4 * (k - 4)));
    end
    @(negedge clk); stall_ifid = 1'b1; #1;
    check_ifid("t2_c10", 32'd24);
    chk("t2_c10_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_c10_req_addr", imem_req_addr, 32'd32);
    @(negedge clk); #1;
    chk("t2_c11_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk); #1;
    chk("t2_c12_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_ifid("t2_c12", 32'd24);
    @(negedge clk); stall_ifid = 1'b0; #1;
    chk("t2_c13_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_ifid("t2_c13", 32'd24);
    @(negedge clk); #1;
    check_ifid("t2_c14", 32'd28);
    chk("t2_c14_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_c14_req_addr", imem_req_addr, 32'd36);
    @(negedge clk); #1;
    check_ifid("t2_c15", 32'd32);
    @(negedge clk); #1;
    check_ifid("t2_c16", 32'd36);

    // Redirect to 0x100 with two requests in flight on a 3-cycle imem.
    do_reset(3); #1;
    chk("t3_c0_req_addr", imem_req_addr, 32'h0);
    @(negedge clk); #1;
    chk("t3_c1_req_addr", imem_req_addr, 32'h4);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; flush_ifid = 1'b1; #1;
    chk("t3_c2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; redirect_pc = 32'd0; flush_ifid = 1'b0; #1;
    chk("t3_c3_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t3_c3_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk); #1;
    chk("t3_c4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t3_c4_req_addr", imem_req_addr, 32'h100);
    chk("t3_c4_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk); #1;
    chk("t3_c5_req_addr", imem_req_addr, 32'h104);
    for (int k = 5; k <= 7; k++) begin
      if (k > 5) begin
        @(negedge clk); #1;
      end
      chk($sformatf("t3_c%0d_ifid_valid", k), {31'd0, ifid_valid}, 32'd0);
    end
    @(negedge clk); #1;
    check_ifid("t3_c8", 32'h100);

    // Redirect coinciding with a live response, with flush.
    do_reset(1);
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; flush_ifid = 1'b1; #1;
    check_ifid("t4_c2", 32'h0);
    chk("t4_c2_rsp_present", {31'd0, imem_rsp_valid}, 32'd1);
    chk("t4_c2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; redirect_pc = 32'd0; flush_ifid = 1'b0; #1;
    chk("t4_c3_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t4_c3_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t4_c3_req_addr", imem_req_addr, 32'h200);
    @(negedge clk); #1;
    chk("t4_c4_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk); #1;
    check_ifid("t4_c5", 32'h200);

    // Ready toggling 1,0,0,1: each address accepted once, in order.
    do_reset(1);
    pat = 4'b1001;
    exp_addr = 32'd0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      imem_req_ready = pat[k % 4]; #1;
      chk($sformatf("t5_c%0d_req_valid", k), {31'd0, imem_req_valid}, 32'd1);
      chk($sformatf("t5_c%0d_req_addr", k), imem_req_addr, exp_addr);
      if (imem_req_ready) exp_addr = exp_addr + 32'd4;
    end
    @(negedge clk); imem_req_ready = 1'b1; #1;
    chk("t5_accept_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < acc_log.size(); i++) begin
      chk($sformatf("t5_accept_%0d", i), acc_log[i], 32'(4 * i));
    end

    // Reset asserted mid-stream with the FIFO full.
    do_reset(1);
    repeat (4) @(negedge clk);
    stall_ifid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t6_full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_ifid("t6_full", 32'h8);
    rst_n = 1'b0; #1;
    chk("t6_rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t6_rst_ifid_instr", ifid_instr, 32'h0000_0013);
    chk("t6_rst_ifid_pc", ifid_pc, 32'd0);
    chk("t6_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    do_reset(1); #1;
    chk("t6_c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t6_c0_req_addr", imem_req_addr, 32'h0);
    @(negedge clk); #1;
    chk("t6_c1_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk); #1;
    check_ifid("t6_c2", 32'h0);
    @(negedge clk); #1;
    check_ifid("t6_c3", 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the in-order RV32I pipeline. Owns the PC register and issues in-order requests to instruction memory. It buffers returned instructions in a small fetch FIFO and drives the IF/ID pipeline register consumed by decode. It obeys the hazard unit's `stall_pc`, `stall_ifid` and `flush_ifid` outputs, and on a taken branch or jump it restarts fetch at the EX-resolved target, squashing stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, fetch FIFO entries; also the cap on live outstanding requests plus buffered instructions (≥2)
- `MAX_OUTSTANDING`, 2, cap on accepted-but-unanswered imem requests, including those to be dropped (1..FIFO_DEPTH)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall_pc`  in  1  hazard unit: hold PC, issue no request
- `stall_ifid`  in  1  hazard unit: hold IF/ID contents
- `flush_ifid`  in  1  hazard unit: invalidate IF/ID
- `redirect_valid`  in  1  EX redirect (taken branch / JAL / JALR)
- `redirect_pc`  in  32  redirect target (EX `ex_target`)
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  imem accepts request this cycle
- `imem_req_addr`  out  32  request address (= pc_q)
- `imem_rsp_valid`  in  1  in-order response, earliest one cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `ifid_valid`  out  1  IF/ID holds a live instruction
- `ifid_pc`  out  32  PC of IF/ID instruction
- `ifid_pc_plus_4`  out  32  ifid_pc + 4
- `ifid_instr`  out  32  instruction word

## Operation
- State: `pc_q`; request-PC queue (MAX_OUTSTANDING entries); `live_cnt` (outstanding, not squashed); `drop_cnt` (outstanding, squashed); FIFO of {pc, instr}; IF/ID register.
- Request, combinational: `imem_req_valid = !redirect_valid && !stall_pc && (live_cnt + drop_cnt < MAX_OUTSTANDING) && (live_cnt + fifo_count < FIFO_DEPTH)`.
- Requests are non-sticky. Valid may drop before acceptance, and only a cycle with valid && ready counts.
- On acceptance: push `pc_q` to the request-PC queue, increment `live_cnt`, and set `pc_q <= pc_q + 4` (mod 2^32).
- Response, with `drop_cnt` > 0: discard the response and decrement `drop_cnt`.
- Response, with `drop_cnt` = 0: pop the request-PC queue and decrement `live_cnt`.
  - If the FIFO is empty and IF/ID loads this cycle, bypass the response directly into IF/ID.
  - Otherwise push it into the FIFO.
- IF/ID update, in priority order:
  1. `flush_ifid`: set `ifid_valid <= 0`.
  2. `stall_ifid`: hold all fields.
  3. Otherwise load the FIFO head (pop), else the bypass response, else set `ifid_valid <= 0`.
- Redirect (has priority over `stall_pc`):
  - Set `pc_q <= redirect_pc`.
  - Clear the FIFO.
  - Set `drop_cnt <= drop_cnt + live_cnt - (squashable response this cycle)`.
  - Set `live_cnt <= 0` and clear the request-PC queue's live entries.
  - The response arriving in the redirect cycle is discarded and is never bypassed.
- `redirect_pc[1:0]` is not checked. The low bits pass through unchanged.

## Timing
- Reset (async assert, sync deassert):
  - `pc_q=RESET_PC`; `live_cnt=drop_cnt=0`; FIFO empty
  - `ifid_valid=0`, `ifid_pc=0`, `ifid_pc_plus_4=4`, `ifid_instr=32'h0000_0013` (NOP)
  - `imem_req_valid=0` while `rst_n` is low.
- First cycle after reset: `imem_req_valid=1`, `imem_req_addr=RESET_PC`.
- Latency with 1-cycle imem: request accepted in cycle N, response in N+1 with bypass, `ifid_valid=1` in N+2.
- Throughput with ready=1, 1-cycle imem and FIFO_DEPTH≥2: one instruction per cycle.
- Redirect asserted in cycle R:
  - `imem_req_valid=0` in R.
  - The request to the target issues in R+1.
  - The first target instruction is in IF/ID at R+3 (1-cycle imem).
- `stall_pc && stall_ifid` (load-use): PC holds and IF/ID holds. Responses already in flight fill the FIFO and are never lost.
- FIFO full with IF/ID stalled: no new requests, because the credit check blocks them.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after `rst_n` rises belong to the imem and must be suppressed by the imem itself.

## Test plan
- Reset, then ready=1 and 1-cycle imem for 8 cycles -> addresses 0,4,8,...; `ifid_pc` 0 at cycle 2, then +4 every cycle; `ifid_pc_plus_4 = ifid_pc + 4`.
- `stall_pc`/`stall_ifid` high for 2 cycles at `ifid_pc=0x8` -> `ifid_pc` holds at 0x8; no request issues; FIFO holds ≤2 entries; resumes with 0xC and no gaps or duplicates.
- `redirect_valid` with `redirect_pc=0x100` while 2 requests are outstanding (3-cycle imem) -> both responses dropped; next `imem_req_addr=0x100`; first valid `ifid_pc=0x100`.
- Redirect in the same cycle a live response returns, plus `flush_ifid` -> `ifid_valid=0` next cycle; the response never appears in IF/ID.
- `imem_req_ready` toggling 1,0,0,1 -> each address is accepted exactly once, in order.
- `rst_n` asserted mid-stream with the FIFO full -> same cycle: `ifid_valid=0`, `ifid_instr=0x13`; after release the first address is `RESET_PC`.
